score_keeper: RTL and testbench

- Downstream consumer of the bubble manager.
- Tracks game progress from the manager's cumulative pop counter (`popCnt`) and bottom bubble row (`BubbleRow4`).
- Produces a 4-digit BCD score, a miss counter, and a game-over flag for the seven-segment display and top-level game FSM.
- Owns the IDLE/PLAY/OVER game-session state machine.

---
 rtl/bubble_pkg.sv | 18 +
 rtl/bcd_inc4.sv | 26 ++
 rtl/score_keeper.sv | 136 +++++++++++++
 tb/tb_score_keeper.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bubble_pkg.sv
// Shared constants and game-session state encoding for the bubble game.
package bubble_pkg;

    localparam int         CELL_W = 5;
    localparam int         COLS   = 8;
    localparam logic [4:0] DARK   = 5'd31;

    localparam logic [4:0] R = 5'd16;
    localparam logic [4:0] G = 5'd17;
    localparam logic [4:0] B = 5'd18;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } state_e;

endpackage

// File: rtl/bcd_inc4.sv
// Combinational 4-digit BCD increment, saturating at 9999.
module bcd_inc4 (
    input  logic [15:0] bcd_i,
    output logic [15:0] bcd_o
);

    logic carry;

    always_comb begin
        bcd_o = bcd_i;
        carry = 1'b1;
        if (bcd_i != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (bcd_i[i*4 +: 4] == 4'd9) begin
                        bcd_o[i*4 +: 4] = 4'd0;
                    end else begin
                        bcd_o[i*4 +: 4] = bcd_i[i*4 +: 4] + 4'd1;
                        carry           = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game-session FSM, BCD score, miss counter for the bubble game.
// Define SCORE_HISCORE_EN to keep a high score across games.
module score_keeper
    import bubble_pkg::*;
#(
    parameter int MISS_LIMIT  = 10,
    parameter int PTS_PER_POP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        dclk,
    input  logic        start,
    input  logic [6:0]  popCnt,
    input  logic [39:0] BubbleRow4,
    output logic [15:0] score_bcd,
    output logic [3:0]  misses,
    output logic        game_over,
    output logic        playing,
    output logic [15:0] hi_score_bcd
);

    state_e      state_q, state_d;
    logic [15:0] score_q, score_d, score_inc;
    logic [3:0]  misses_q, misses_d;
    logic [8:0]  pending_q, pending_d;
    logic        prev_dclk_q;
    logic [6:0]  prev_pop_q;

    logic        tick;
    logic        drain;
    logic [6:0]  delta;
    logic [11:0] add;
    logic [12:0] pend_sum;
    logic [3:0]  row_cnt;
    logic [4:0]  miss_sum;
    logic        limit_hit;

    assign tick      = dclk & ~prev_dclk_q;
    assign drain     = (pending_q != 9'd0);
    // A falling pop count means the manager was reset: no credit.
    assign delta     = (popCnt >= prev_pop_q) ? popCnt - prev_pop_q : 7'd0;
    assign add       = 12'(delta) * 12'(PTS_PER_POP);
    assign pend_sum  = 13'(pending_q) + 13'(add) - 13'(drain);
    assign miss_sum  = {1'b0, misses_q} + {1'b0, row_cnt};
    assign limit_hit = (misses_q >= 4'(MISS_LIMIT));

    bcd_inc4 u_inc (
        .bcd_i (score_q),
        .bcd_o (score_inc)
    );

    always_comb begin
        row_cnt = 4'd0;
        for (int i = 0; i < COLS; i++) begin
            if (BubbleRow4[i*CELL_W +: CELL_W] != DARK) begin
                row_cnt = row_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        misses_d  = misses_q;
        pending_d = pending_q;
        if (en) begin
            unique case (state_q)
                IDLE, OVER: begin
                    if (start) begin
                        state_d   = PLAY;
                        score_d   = 16'h0000;
                        misses_d  = 4'd0;
                        pending_d = 9'd0;
                    end
                end
                PLAY: begin
                    if (limit_hit) begin
                        state_d = OVER;
                    end else begin
                        pending_d = (pend_sum > 13'd511) ? 9'd511 : pend_sum[8:0];
                        if (drain) score_d = score_inc;
                        if (tick) begin
                            misses_d = (miss_sum > 5'd15) ? 4'd15 : miss_sum[3:0];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            score_q     <= 16'h0000;
            misses_q    <= 4'd0;
            pending_q   <= 9'd0;
            prev_dclk_q <= 1'b0;
            prev_pop_q  <= 7'd0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            pending_q   <= pending_d;
            prev_dclk_q <= dclk;
            prev_pop_q  <= popCnt;
        end
    end

`ifdef SCORE_HISCORE_EN
    logic [15:0] hi_q;
    logic        go_over;

    assign go_over = en && (state_q == PLAY) && limit_hit;

    // Valid BCD orders the same as binary, so a plain compare suffices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= 16'h0000;
        end else if (go_over && (score_q > hi_q)) begin
            hi_q <= score_q;
        end
    end

    assign hi_score_bcd = hi_q;
`else
    assign hi_score_bcd = 16'h0000;
`endif

    assign score_bcd = score_q;
    assign misses    = misses_q;
    assign game_over = (state_q == OVER);
    assign playing   = (state_q == PLAY);

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst, en, dclk, start;
    logic [6:0]  popCnt;
    logic [39:0] row;
    logic [15:0] score_bcd, hi_score_bcd;
    logic [3:0]  misses;
    logic        game_over, playing;

    int total = 0;
    int bad   = 0;

    localparam logic [39:0] ROW_DARK = {8{5'd31}};
    localparam logic [39:0] ROW5 =
        {5'd31, 5'd31, 5'd31, 5'd16, 5'd17, 5'd18, 5'd0, 5'd30};

`ifdef SCORE_HISCORE_EN
    localparam bit HI_ON = 1'b1;
`else
    localparam bit HI_ON = 1'b0;
`endif

    score_keeper #(.MISS_LIMIT(10), .PTS_PER_POP(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .dclk         (dclk),
        .start        (start),
        .popCnt       (popCnt),
        .BubbleRow4   (row),
        .score_bcd    (score_bcd),
        .misses       (misses),
        .game_over    (game_over),
        .playing      (playing),
        .hi_score_bcd (hi_score_bcd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hexp(input logic [15:0] v);
        return HI_ON ? v : 16'h0000;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Feed n points in chunks, letting pending drain after each.
    task automatic add_pops(input int n);
        int left;
        int chunk;
        left = n;
        while (left > 0) begin
            chunk = (left > 100) ? 100 : left;
            if (int'(popCnt) + chunk > 127) begin
                popCnt = 7'd0;
                step(1);
            end
            popCnt = popCnt + 7'(chunk);
            step(chunk + 3);
            left -= chunk;
        end
    endtask

    task automatic start_game();
        dclk  = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic end_game();
        row  = ROW5;
        dclk = 1'b1; step(1);
        dclk = 1'b0; step(1);
        dclk = 1'b1; step(1);
        dclk = 1'b0; step(1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; dclk = 1'b0; start = 1'b0;
        popCnt = 7'd0; row = ROW_DARK;
        step(2);
        chk("rst_score", score_bcd, 16'h0000);
        chk("rst_misses", 16'(misses), 16'd0);
        chk("rst_over", 16'(game_over), 16'd0);
        chk("rst_play", 16'(playing), 16'd0);
        chk("rst_hi", hi_score_bcd, 16'h0000);
        rst = 1'b0;
        step(1);
        chk("idle_play", 16'(playing), 16'd0);

        start_game();
        chk("g1_play", 16'(playing), 16'd1);
        chk("g1_over", 16'(game_over), 16'd0);

        popCnt = 7'd3;
        step(1);
        chk("pop3_early", score_bcd, 16'h0000);
        step(3);
        chk("pop3", score_bcd, 16'h0003);
        step(2);
        chk("pop3_hold", score_bcd, 16'h0003);

        popCnt = 7'd120;
        step(125);
        chk("pop120", score_bcd, 16'h0120);
        popCnt = 7'd0;
        step(5);
        chk("wrap_nochg", score_bcd, 16'h0120);

        row  = ROW5;
        dclk = 1'b1;
        step(100);
        chk("dclk_high_once", 16'(misses), 16'd5);
        chk("still_play", 16'(playing), 16'd1);
        dclk = 1'b0; step(1);
        dclk = 1'b1; step(1);
        chk("miss10", 16'(misses), 16'd10);
        chk("miss10_notover", 16'(game_over), 16'd0);
        step(1);
        chk("over", 16'(game_over), 16'd1);
        chk("over_noplay", 16'(playing), 16'd0);
        popCnt = 7'd10;
        step(5);
        chk("over_frozen", score_bcd, 16'h0120);
        dclk = 1'b0; step(1);
        dclk = 1'b1; step(1);
        chk("over_notick", 16'(misses), 16'd10);
        chk("hi_g1", hi_score_bcd, hexp(16'h0120));

        start_game();
        chk("g2_play", 16'(playing), 16'd1);
        chk("g2_clr_score", score_bcd, 16'h0000);
        chk("g2_clr_miss", 16'(misses), 16'd0);
        popCnt = 7'd27;
        step(20);
        chk("g2_17", score_bcd, 16'h0017);
        en = 1'b0;
        popCnt = 7'd40;
        step(5);
        chk("en0_hold", score_bcd, 16'h0017);
        en = 1'b1;
        step(5);
        chk("en1_nostale", score_bcd, 16'h0017);
        end_game();
        chk("g2_over", 16'(game_over), 16'd1);
        chk("hi_g2", hi_score_bcd, hexp(16'h0120));

        start_game();
        add_pops(1009);
        chk("bcd_1009", score_bcd, 16'h1009);
        add_pops(1);
        chk("bcd_1010", score_bcd, 16'h1010);
        add_pops(8995);
        chk("bcd_sat", score_bcd, 16'h9999);
        add_pops(3);
        chk("bcd_sat_hold", score_bcd, 16'h9999);
        end_game();
        chk("hi_g3", hi_score_bcd, hexp(16'h9999));

        start_game();
        add_pops(42);
        chk("g4_42", score_bcd, 16'h0042);
        #2 rst = 1'b1;
        #1;
        chk("arst_score", score_bcd, 16'h0000);
        chk("arst_play", 16'(playing), 16'd0);
        chk("arst_over", 16'(game_over), 16'd0);
        chk("arst_hi", hi_score_bcd, 16'h0000);
        step(1);
        rst = 1'b0;
        start_game();
        chk("post_rst_play", 16'(playing), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
